sha_host_bridge: RTL and testbench
==================================

Name: sha_host_bridge

Overview:
- Parametrised successor to the miner's byte-serial host front end: bridges an external req/ready host port (IO_W-bit beats) to a hash core's word-request port (WORD_W-bit words), then streams the DIGEST_W-bit digest back out.
- Beyond the previous generation it adds:
  - configurable beat, word and digest widths;
  - a digest snapshot register, so the core is free once done;
  - runtime readback order;
  - host abort with sticky error status.
- Sits between the chip pins and sha256d_wrapper-class cores.

Parameters:
- IO_W, 8, host beat width; WORD_W % IO_W == 0 and DIGEST_W % IO_W == 0 are required (elaboration error otherwise).
- WORD_W, 32, core input word width.
- DIGEST_W, 256, core digest width.
- Derived: WBEATS = WORD_W/IO_W; DBEATS = DIGEST_W/IO_W; CNT_W = clog2(max(WBEATS, DBEATS)).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- h_start  in  1  begin job (level, sampled in IDLE)
- h_lsb_first  in  1  readback order, sampled with h_start (0 = MS beat first)
- h_abort  in  1  cancel job
- h_rdy  in  1  host ready; a transfer occurs on any cycle with h_rq && h_rdy
- h_data  in  IO_W  host write beat
- h_rq  out  1  bridge requests a beat (write in FEED, read in READ)
- h_dout  out  IO_W  digest beat
- h_done  out  1  digest available / readback in progress
- h_busy  out  1  state != IDLE
- h_err  out  1  sticky: last job was aborted
- c_start  out  1  one-cycle core start pulse
- c_rq  in  1  core wants a word
- c_rdy  out  1  one-cycle pulse: c_data valid
- c_data  out  WORD_W  assembled word
- c_done  in  1  core digest valid
- c_digest  in  DIGEST_W  core digest
- c_abort  out  1  one-cycle core soft-reset pulse

Behaviour:
- Reset values: every output 0, including c_data, the digest register and the beat counter; state = IDLE.
- An asynchronous reset mid-job returns all of this immediately, with no further pulses.

IDLE:
- h_start = 1 produces the following on the next edge:
  - state = FEED and c_start = 1 for exactly one cycle;
  - the order bit is latched and the beat counter cleared;
  - h_err is cleared and h_busy = 1.

FEED, word assembly:
- A word is needed when c_rq = 1, c_rdy = 0, and the previous cycle had no c_rdy (one-cycle guard, so the core has time to drop c_rq).
- While a word is needed, h_rq rises on the next edge (registered).
- On a transfer:
  - h_data shifts into the word register from the LS end, so the first beat lands in the MS position;
  - the counter increments;
  - h_rq drops for at least one cycle.
- On the WBEATS-th transfer:
  - c_data updates and c_rdy = 1 on the next edge, for exactly one cycle;
  - the counter resets.
- c_data holds until the next word completes.

FEED, completion:
- c_done = 1 produces the following on the next edge:
  - c_digest is captured into the digest register;
  - h_done = 1, h_rq = 0, counter = 0, state = READ.
- Any partially assembled word is discarded.
- If c_done coincides with a host transfer, c_done wins and that beat is dropped.

READ:
- h_dout = digest beat[idx]:
  - MS-first: bits [DIGEST_W-1-idx*IO_W -: IO_W];
  - LS-first: bits [idx*IO_W +: IO_W].
- h_dout is combinational from registered state and stable while h_rq = 1.
- h_rq uses the same request/drop handshake as FEED; each transfer increments idx.
- On the DBEATS-th transfer: h_done = 0, h_busy = 0, state = IDLE on the next edge.
- h_dout = 0 outside READ.

Abort:
- h_abort in a non-IDLE state has priority over everything. On the next edge:
  - state = IDLE;
  - h_rq, h_done and h_busy = 0;
  - c_abort = 1 for one cycle;
  - h_err = 1;
  - counter cleared; the digest register is kept.
- h_abort in IDLE is ignored.

Other boundary rules:
- h_start while busy is ignored.
- h_start high continuously restarts a new job one cycle after returning to IDLE.
- c_rq in READ is ignored.
- All counters wrap only through explicit reset at their last beat, never by overflow.

State encoding: IDLE = 0, FEED = 1, READ = 2. Encoding 3 → IDLE; this decode does not raise c_abort.

Decomposition:
- Package sha_bridge_pkg holds:
  - the state enum {S_IDLE, S_FEED, S_READ};
  - a clog2 helper function;
  - the ORDER_MSB / ORDER_LSB constants.
- One sub-module, sha_beat_packer (parameters IO_W, WORD_W):
  - ports: shift-enable, clear, data in;
  - outputs: word and last-beat flag.
- The FSM, handshake, guard and digest mux stay in sha_host_bridge.

Test Plan:
1. IO_W = 8. Core model raises c_rq; host answers beats 0x01, 0x23, 0x45, 0x67, holding h_rdy off for 2 cycles after each rq → c_data = 0x01234567; c_rdy high exactly one cycle, the cycle after the 4th transfer; no new h_rq in the guard cycle.
2. c_digest = bytes 0x00..0x1F (MS = 0x00), h_lsb_first = 0 → 32 reads return 0x00, 0x01, ..., 0x1F; h_done falls and h_busy = 0 one cycle after the 32nd transfer.
3. Same digest with h_lsb_first = 1 latched at start, toggled to 0 mid-job → first read 0x1F, last read 0x00 (latched value used).
4. Abort after 2 of 4 beats → next cycle: c_abort pulse, h_err = 1, IDLE; c_data unchanged. A new start clears h_err; the next word assembles cleanly from 4 fresh beats.
5. c_done on the same edge as the 3rd beat transfer → READ entered, no c_rdy pulse, digest captured. Changing c_digest afterwards does not alter h_dout.
6. IO_W = 16, WORD_W = 32, DIGEST_W = 256 → two beats 0xDEAD, 0xBEEF give c_data = 0xDEADBEEF; readback takes exactly 16 transfers. Async reset asserted mid-READ → all outputs 0 immediately.

Source files
------------

// File: rtl/sha_bridge_pkg.sv
// Shared definitions for the SHA host bridge: state encoding, readback order
// constants and a constant-function clog2 for sizing counters.
package sha_bridge_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_READ = 2'd2
   } bridge_state_e;

   localparam logic ORDER_MSB = 1'b0;
   localparam logic ORDER_LSB = 1'b1;

   // Ceiling log2, never below 1 so counters always have at least one bit.
   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      while ((32'sd1 <<< r) < value) begin
         r = r + 32'sd1;
      end
      if (r < 32'sd1) begin
         r = 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sha_beat_packer.sv
// Shifts host beats into a core word, MS beat first, and flags the final beat
// of each word. word is the value the register would hold after this shift.
module sha_beat_packer
   import sha_bridge_pkg::*;
#(
   parameter int IO_W   = 8,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic              clear,
   input  logic [IO_W-1:0]   din,
   output logic [WORD_W-1:0] word,
   output logic              last
);

   localparam int WBEATS = WORD_W / IO_W;
   localparam int PK_W   = clog2(WBEATS);

   logic [PK_W-1:0] cnt_r;

   assign last = (cnt_r == PK_W'(WBEATS - 1));

   if (WBEATS > 1) begin : g_multi
      localparam int SH_W = WORD_W - IO_W;
      logic [SH_W-1:0] sh_r;

      assign word = {sh_r, din};

      // Holds the beats already received for the word in progress.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sh_r <= '0;
         end else if (clear) begin
            sh_r <= '0;
         end else if (shift_en && last) begin
            sh_r <= '0;
         end else if (shift_en) begin
            sh_r <= word[SH_W-1:0];
         end else begin
            sh_r <= sh_r;
         end
      end
   end else begin : g_single
      assign word = din;
   end

   // Beat position within the current word; wraps only at the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (shift_en && last) begin
         cnt_r <= '0;
      end else if (shift_en) begin
         cnt_r <= cnt_r + PK_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/sha_host_bridge.sv
// Bridges a beat-wide req/ready host port to a hash core's word-request port,
// snapshots the core digest and streams it back in a runtime-selected order.
module sha_host_bridge
   import sha_bridge_pkg::*;
#(
   parameter int IO_W     = 8,
   parameter int WORD_W   = 32,
   parameter int DIGEST_W = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                h_start,
   input  logic                h_lsb_first,
   input  logic                h_abort,
   input  logic                h_rdy,
   input  logic [IO_W-1:0]     h_data,
   output logic                h_rq,
   output logic [IO_W-1:0]     h_dout,
   output logic                h_done,
   output logic                h_busy,
   output logic                h_err,
   output logic                c_start,
   input  logic                c_rq,
   output logic                c_rdy,
   output logic [WORD_W-1:0]   c_data,
   input  logic                c_done,
   input  logic [DIGEST_W-1:0] c_digest,
   output logic                c_abort
);

   localparam int WBEATS = WORD_W / IO_W;
   localparam int DBEATS = DIGEST_W / IO_W;
   localparam int CNT_W  = clog2((WBEATS > DBEATS) ? WBEATS : DBEATS);

   localparam logic [1:0] ST_IDLE = S_IDLE;
   localparam logic [1:0] ST_FEED = S_FEED;
   localparam logic [1:0] ST_READ = S_READ;

   if (((WORD_W % IO_W) != 0) || ((DIGEST_W % IO_W) != 0)) begin : g_bad_cfg
      $error("sha_host_bridge: WORD_W and DIGEST_W must be multiples of IO_W");
   end

   logic [1:0]          state_r;
   logic                order_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                h_rq_r;
   logic                h_done_r;
   logic                h_busy_r;
   logic                h_err_r;
   logic                c_start_r;
   logic                c_rdy_r;
   logic                c_rdy_d_r;
   logic                c_abort_r;
   logic [WORD_W-1:0]   c_data_r;
   logic [DIGEST_W-1:0] digest_r;

   logic                xfer_s;
   logic                need_s;
   logic                abort_s;
   logic                last_rd_s;
   logic                pk_shift_s;
   logic                pk_clear_s;
   logic                pk_last_s;
   logic [WORD_W-1:0]   pk_word_s;
   logic [CNT_W-1:0]    sel_s;
   logic [IO_W-1:0]     dout_s;

   assign xfer_s    = h_rq_r & h_rdy;
   // The c_rdy_d_r term gives the core one cycle to drop c_rq after a word.
   assign need_s    = c_rq & ~c_rdy_r & ~c_rdy_d_r;
   assign abort_s   = h_abort & ((state_r == ST_FEED) | (state_r == ST_READ));
   assign last_rd_s = (cnt_r == CNT_W'(DBEATS - 1));

   assign pk_shift_s = (state_r == ST_FEED) & xfer_s & ~abort_s & ~c_done;
   assign pk_clear_s = abort_s
                     | ((state_r == ST_FEED) & c_done)
                     | ((state_r == ST_IDLE) & h_start);

   sha_beat_packer #(
      .IO_W   (IO_W),
      .WORD_W (WORD_W)
   ) u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (pk_shift_s),
      .clear    (pk_clear_s),
      .din      (h_data),
      .word     (pk_word_s),
      .last     (pk_last_s)
   );

   // Selects the digest beat for the current read index in the latched order.
   always_comb begin
      sel_s  = '0;
      dout_s = '0;
      case (order_r)
         ORDER_MSB: sel_s = CNT_W'(DBEATS - 1) - cnt_r;
         ORDER_LSB: sel_s = cnt_r;
         default:   sel_s = '0;
      endcase
      if (state_r == ST_READ) begin
         dout_s = digest_r[sel_s * IO_W +: IO_W];
      end else begin
         dout_s = '0;
      end
   end

   // Job FSM with host/core handshakes; abort overrides every other action.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         order_r   <= 1'b0;
         cnt_r     <= '0;
         h_rq_r    <= 1'b0;
         h_done_r  <= 1'b0;
         h_busy_r  <= 1'b0;
         h_err_r   <= 1'b0;
         c_start_r <= 1'b0;
         c_rdy_r   <= 1'b0;
         c_rdy_d_r <= 1'b0;
         c_abort_r <= 1'b0;
         c_data_r  <= '0;
         digest_r  <= '0;
      end else begin
         c_start_r <= 1'b0;
         c_abort_r <= 1'b0;
         c_rdy_r   <= 1'b0;
         c_rdy_d_r <= c_rdy_r;
         if (abort_s) begin
            state_r   <= ST_IDLE;
            h_rq_r    <= 1'b0;
            h_done_r  <= 1'b0;
            h_busy_r  <= 1'b0;
            h_err_r   <= 1'b1;
            c_abort_r <= 1'b1;
            cnt_r     <= '0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (h_start) begin
                     state_r   <= ST_FEED;
                     c_start_r <= 1'b1;
                     order_r   <= h_lsb_first;
                     cnt_r     <= '0;
                     h_err_r   <= 1'b0;
                     h_busy_r  <= 1'b1;
                     h_rq_r    <= 1'b0;
                     h_done_r  <= 1'b0;
                  end else begin
                     h_rq_r    <= 1'b0;
                  end
               end
               ST_FEED: begin
                  if (c_done) begin
                     digest_r <= c_digest;
                     h_done_r <= 1'b1;
                     h_rq_r   <= 1'b0;
                     cnt_r    <= '0;
                     state_r  <= ST_READ;
                  end else begin
                     h_rq_r <= need_s & ~xfer_s;
                     if (pk_shift_s && pk_last_s) begin
                        c_data_r <= pk_word_s;
                        c_rdy_r  <= 1'b1;
                     end else begin
                        c_data_r <= c_data_r;
                     end
                  end
               end
               ST_READ: begin
                  if (xfer_s) begin
                     h_rq_r <= 1'b0;
                     if (last_rd_s) begin
                        state_r  <= ST_IDLE;
                        h_done_r <= 1'b0;
                        h_busy_r <= 1'b0;
                        cnt_r    <= '0;
                     end else begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                     end
                  end else begin
                     h_rq_r <= 1'b1;
                  end
               end
               default: begin
                  state_r  <= ST_IDLE;
                  h_rq_r   <= 1'b0;
                  h_done_r <= 1'b0;
                  h_busy_r <= 1'b0;
                  cnt_r    <= '0;
               end
            endcase
         end
      end
   end

   assign h_rq    = h_rq_r;
   assign h_dout  = dout_s;
   assign h_done  = h_done_r;
   assign h_busy  = h_busy_r;
   assign h_err   = h_err_r;
   assign c_start = c_start_r;
   assign c_rdy   = c_rdy_r;
   assign c_data  = c_data_r;
   assign c_abort = c_abort_r;

endmodule

// File: tb/tb_sha_host_bridge.sv
// Directed self-checking bench for sha_host_bridge: an 8-bit-beat instance for
// the main scenarios and a 16-bit-beat instance for width scaling and reset.
module tb_sha_host_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic         rst8_n, h_start8, h_lsb8, h_abort8, h_rdy8;
   logic [7:0]   h_data8, h_dout8;
   logic         h_rq8, h_done8, h_busy8, h_err8, c_start8, c_rq8, c_rdy8;
   logic [31:0]  c_data8;
   logic         c_done8, c_abort8;
   logic [255:0] c_digest8;

   logic         rst16_n, h_start16, h_lsb16, h_abort16, h_rdy16;
   logic [15:0]  h_data16, h_dout16;
   logic         h_rq16, h_done16, h_busy16, h_err16, c_start16, c_rq16, c_rdy16;
   logic [31:0]  c_data16;
   logic         c_done16, c_abort16;
   logic [255:0] c_digest16;

   sha_host_bridge #(.IO_W(8), .WORD_W(32), .DIGEST_W(256)) dut8 (
      .clk(clk), .rst_n(rst8_n), .h_start(h_start8), .h_lsb_first(h_lsb8),
      .h_abort(h_abort8), .h_rdy(h_rdy8), .h_data(h_data8), .h_rq(h_rq8),
      .h_dout(h_dout8), .h_done(h_done8), .h_busy(h_busy8), .h_err(h_err8),
      .c_start(c_start8), .c_rq(c_rq8), .c_rdy(c_rdy8), .c_data(c_data8),
      .c_done(c_done8), .c_digest(c_digest8), .c_abort(c_abort8));

   sha_host_bridge #(.IO_W(16), .WORD_W(32), .DIGEST_W(256)) dut16 (
      .clk(clk), .rst_n(rst16_n), .h_start(h_start16), .h_lsb_first(h_lsb16),
      .h_abort(h_abort16), .h_rdy(h_rdy16), .h_data(h_data16), .h_rq(h_rq16),
      .h_dout(h_dout16), .h_done(h_done16), .h_busy(h_busy16), .h_err(h_err16),
      .c_start(c_start16), .c_rq(c_rq16), .c_rdy(c_rdy16), .c_data(c_data16),
      .c_done(c_done16), .c_digest(c_digest16), .c_abort(c_abort16));

   // Digest whose k-th byte from the MS end is base+k.
   function automatic logic [255:0] mk_dig8(input logic [7:0] base);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) r[255 - 8*k -: 8] = base + 8'(k);
      return r;
   endfunction

   task automatic wait_rq8(input string tag);
      int n;
      n = 0;
      while (h_rq8 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests++;
      if (h_rq8 !== 1'b1) begin
         fails++;
         $display("FAIL %s_rq_timeout: h_rq=%b after %0d cycles, expected 1", tag, h_rq8, n);
      end
   endtask

   task automatic wait_rq16(input string tag);
      int n;
      n = 0;
      while (h_rq16 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests++;
      if (h_rq16 !== 1'b1) begin
         fails++;
         $display("FAIL %s_rq_timeout: h_rq=%b after %0d cycles, expected 1", tag, h_rq16, n);
      end
   endtask

   task automatic beat8(input logic [7:0] d, input string tag);
      wait_rq8(tag);
      h_data8 = d;
      h_rdy8  = 1'b1;
      @(negedge clk);
      h_rdy8  = 1'b0;
   endtask

   task automatic start8(input logic lsb);
      h_start8 = 1'b1;
      h_lsb8   = lsb;
      @(negedge clk);
      h_start8 = 1'b0;
   endtask

   task automatic read_all8(input logic lsb, input logic [7:0] base, input string tag);
      logic [7:0] exp;
      for (int i = 0; i < 32; i++) begin
         wait_rq8(tag);
         exp = lsb ? (base + 8'(31 - i)) : (base + 8'(i));
         tests++;
         if (h_dout8 !== exp) begin
            fails++;
            $display("FAIL %s_beat%0d: h_dout=%h expected %h", tag, i, h_dout8, exp);
         end
         h_rdy8 = 1'b1;
         @(negedge clk);
         h_rdy8 = 1'b0;
      end
      tests++;
      if ({h_done8, h_busy8, h_rq8, h_dout8} !== 11'b0) begin
         fails++;
         $display("FAIL %s_end: done/busy/rq/dout=%b%b%b/%h expected 000/00", tag,
                  h_done8, h_busy8, h_rq8, h_dout8);
      end
   endtask

   task automatic test_reset;
      rst8_n = 1'b1; rst16_n = 1'b1;
      #2;
      rst8_n = 1'b0; rst16_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({h_rq8, h_done8, h_busy8, h_err8, c_start8, c_rdy8, c_abort8, h_dout8, c_data8} !== 47'b0) begin
         fails++;
         $display("FAIL reset8: rq/done/busy/err/start/rdy/abort=%b%b%b%b%b%b%b dout=%h cdata=%h expected all 0",
                  h_rq8, h_done8, h_busy8, h_err8, c_start8, c_rdy8, c_abort8, h_dout8, c_data8);
      end
      tests++;
      if ({h_rq16, h_done16, h_busy16, h_err16, c_start16, c_rdy16, c_abort16, h_dout16, c_data16} !== 55'b0) begin
         fails++;
         $display("FAIL reset16: outputs not all 0 (dout=%h cdata=%h)", h_dout16, c_data16);
      end
      rst8_n = 1'b1; rst16_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({h_rq8, h_busy8, c_start8} !== 3'b0) begin
         fails++;
         $display("FAIL post_reset_idle: rq/busy/start=%b%b%b expected 000", h_rq8, h_busy8, c_start8);
      end
   endtask

   task automatic test_idle_abort;
      h_abort8 = 1'b1;
      @(negedge clk);
      h_abort8 = 1'b0;
      tests++;
      if ({c_abort8, h_err8, h_busy8} !== 3'b0) begin
         fails++;
         $display("FAIL idle_abort: c_abort/h_err/h_busy=%b%b%b expected 000", c_abort8, h_err8, h_busy8);
      end
   endtask

   task automatic test_word_assembly;
      logic [7:0] bts [4];
      bts = '{8'h01, 8'h23, 8'h45, 8'h67};
      start8(1'b0);
      tests++;
      if ({c_start8, h_busy8, h_err8, h_rq8} !== 4'b1100) begin
         fails++;
         $display("FAIL start: start/busy/err/rq=%b%b%b%b expected 1100", c_start8, h_busy8, h_err8, h_rq8);
      end
      @(negedge clk);
      tests++;
      if (c_start8 !== 1'b0) begin
         fails++;
         $display("FAIL start_pulse_width: c_start=%b expected 0", c_start8);
      end
      c_rq8 = 1'b1;
      for (int b = 0; b < 4; b++) begin
         wait_rq8("word");
         repeat (2) begin
            @(negedge clk);
            tests++;
            if (h_rq8 !== 1'b1) begin
               fails++;
               $display("FAIL word_rq_hold%0d: h_rq=%b expected 1", b, h_rq8);
            end
         end
         h_data8 = bts[b];
         h_rdy8  = 1'b1;
         @(negedge clk);
         h_rdy8  = 1'b0;
         tests++;
         if ({h_rq8, c_rdy8} !== {1'b0, (b == 3)}) begin
            fails++;
            $display("FAIL word_after_beat%0d: rq/c_rdy=%b%b expected 0%b", b, h_rq8, c_rdy8, (b == 3));
         end
      end
      tests++;
      if (c_data8 !== 32'h01234567) begin
         fails++;
         $display("FAIL word_data: c_data=%h expected 01234567", c_data8);
      end
      @(negedge clk);
      tests++;
      if ({c_rdy8, h_rq8} !== 2'b00) begin
         fails++;
         $display("FAIL word_rdy_width: c_rdy/h_rq=%b%b expected 00", c_rdy8, h_rq8);
      end
      @(negedge clk);
      tests++;
      if (h_rq8 !== 1'b0) begin
         fails++;
         $display("FAIL word_guard: h_rq=%b expected 0", h_rq8);
      end
      c_rq8 = 1'b0;
   endtask

   task automatic test_readback_msb;
      c_digest8 = mk_dig8(8'h00);
      c_done8   = 1'b1;
      @(negedge clk);
      c_done8   = 1'b0;
      tests++;
      if ({h_done8, h_busy8, h_rq8} !== 3'b110) begin
         fails++;
         $display("FAIL msb_enter_read: done/busy/rq=%b%b%b expected 110", h_done8, h_busy8, h_rq8);
      end
      read_all8(1'b0, 8'h00, "msb");
   endtask

   task automatic test_readback_lsb;
      start8(1'b1);
      h_lsb8  = 1'b0;
      c_done8 = 1'b1;
      @(negedge clk);
      c_done8 = 1'b0;
      read_all8(1'b1, 8'h00, "lsb");
   endtask

   task automatic test_abort;
      start8(1'b0);
      c_rq8 = 1'b1;
      beat8(8'hAA, "abort_b0");
      beat8(8'hBB, "abort_b1");
      h_abort8 = 1'b1;
      @(negedge clk);
      h_abort8 = 1'b0;
      c_rq8    = 1'b0;
      tests++;
      if ({c_abort8, h_err8, h_busy8, h_rq8, h_done8} !== 5'b11000) begin
         fails++;
         $display("FAIL abort: abort/err/busy/rq/done=%b%b%b%b%b expected 11000",
                  c_abort8, h_err8, h_busy8, h_rq8, h_done8);
      end
      tests++;
      if (c_data8 !== 32'h01234567) begin
         fails++;
         $display("FAIL abort_cdata: c_data=%h expected 01234567", c_data8);
      end
      @(negedge clk);
      tests++;
      if ({c_abort8, h_err8} !== 2'b01) begin
         fails++;
         $display("FAIL abort_sticky: c_abort/h_err=%b%b expected 01", c_abort8, h_err8);
      end
      start8(1'b0);
      tests++;
      if ({h_err8, h_busy8} !== 2'b01) begin
         fails++;
         $display("FAIL abort_restart: h_err/h_busy=%b%b expected 01", h_err8, h_busy8);
      end
      c_rq8 = 1'b1;
      beat8(8'h89, "fresh_b0");
      beat8(8'hAB, "fresh_b1");
      tests++;
      if (c_rdy8 !== 1'b0) begin
         fails++;
         $display("FAIL fresh_early_rdy: c_rdy=%b expected 0", c_rdy8);
      end
      beat8(8'hCD, "fresh_b2");
      beat8(8'hEF, "fresh_b3");
      tests++;
      if ({c_rdy8, c_data8} !== {1'b1, 32'h89ABCDEF}) begin
         fails++;
         $display("FAIL fresh_word: c_rdy=%b c_data=%h expected 1 89abcdef", c_rdy8, c_data8);
      end
      c_rq8 = 1'b0;
   endtask

   task automatic test_done_priority;
      repeat (2) @(negedge clk);
      c_rq8 = 1'b1;
      beat8(8'h11, "prio_b0");
      beat8(8'h22, "prio_b1");
      wait_rq8("prio_b2");
      h_data8   = 8'h33;
      h_rdy8    = 1'b1;
      c_done8   = 1'b1;
      c_digest8 = mk_dig8(8'h40);
      @(negedge clk);
      h_rdy8  = 1'b0;
      c_done8 = 1'b0;
      c_rq8   = 1'b0;
      tests++;
      if ({c_rdy8, h_done8, h_busy8, h_rq8} !== 4'b0110) begin
         fails++;
         $display("FAIL prio_enter_read: rdy/done/busy/rq=%b%b%b%b expected 0110",
                  c_rdy8, h_done8, h_busy8, h_rq8);
      end
      tests++;
      if (c_data8 !== 32'h89ABCDEF) begin
         fails++;
         $display("FAIL prio_cdata: c_data=%h expected 89abcdef", c_data8);
      end
      c_digest8 = mk_dig8(8'h90);
      read_all8(1'b0, 8'h40, "snap");
   endtask

   task automatic test_wide;
      logic [15:0] exp;
      h_start16 = 1'b1;
      @(negedge clk);
      h_start16 = 1'b0;
      c_rq16    = 1'b1;
      wait_rq16("w16_b0");
      h_data16 = 16'hDEAD; h_rdy16 = 1'b1;
      @(negedge clk);
      h_rdy16 = 1'b0;
      wait_rq16("w16_b1");
      h_data16 = 16'hBEEF; h_rdy16 = 1'b1;
      @(negedge clk);
      h_rdy16 = 1'b0;
      c_rq16  = 1'b0;
      tests++;
      if ({c_rdy16, c_data16} !== {1'b1, 32'hDEADBEEF}) begin
         fails++;
         $display("FAIL w16_word: c_rdy=%b c_data=%h expected 1 deadbeef", c_rdy16, c_data16);
      end
      for (int k = 0; k < 16; k++) c_digest16[255 - 16*k -: 16] = 16'h1000 + 16'(k);
      c_done16 = 1'b1;
      @(negedge clk);
      c_done16 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wait_rq16("w16_rd");
         exp = 16'h1000 + 16'(i);
         tests++;
         if (h_dout16 !== exp) begin
            fails++;
            $display("FAIL w16_beat%0d: h_dout=%h expected %h", i, h_dout16, exp);
         end
         h_rdy16 = 1'b1;
         @(negedge clk);
         h_rdy16 = 1'b0;
         if (i == 14) begin
            tests++;
            if (h_done16 !== 1'b1) begin
               fails++;
               $display("FAIL w16_early_end: h_done=%b expected 1 after 15 transfers", h_done16);
            end
         end
      end
      tests++;
      if ({h_done16, h_busy16} !== 2'b00) begin
         fails++;
         $display("FAIL w16_end: done/busy=%b%b expected 00", h_done16, h_busy16);
      end
      h_start16 = 1'b1;
      @(negedge clk);
      h_start16 = 1'b0;
      c_done16  = 1'b1;
      @(negedge clk);
      c_done16  = 1'b0;
      repeat (2) begin
         wait_rq16("w16_rst_rd");
         h_rdy16 = 1'b1;
         @(negedge clk);
         h_rdy16 = 1'b0;
      end
      wait_rq16("w16_rst_pre");
      @(posedge clk);
      #2;
      rst16_n = 1'b0;
      #1;
      tests++;
      if ({h_rq16, h_done16, h_busy16, h_err16, c_start16, c_rdy16, c_abort16, h_dout16, c_data16} !== 55'b0) begin
         fails++;
         $display("FAIL w16_async_reset: rq/done/busy=%b%b%b dout=%h cdata=%h expected all 0",
                  h_rq16, h_done16, h_busy16, h_dout16, c_data16);
      end
      @(negedge clk);
      rst16_n = 1'b1;
   endtask

   initial begin
      h_start8 = 1'b0; h_lsb8 = 1'b0; h_abort8 = 1'b0; h_rdy8 = 1'b0; h_data8 = 8'h00;
      c_rq8 = 1'b0; c_done8 = 1'b0; c_digest8 = '0;
      h_start16 = 1'b0; h_lsb16 = 1'b0; h_abort16 = 1'b0; h_rdy16 = 1'b0; h_data16 = 16'h0000;
      c_rq16 = 1'b0; c_done16 = 1'b0; c_digest16 = '0;
      test_reset();
      test_idle_abort();
      test_word_assembly();
      test_readback_msb();
      test_readback_lsb();
      test_abort();
      test_done_priority();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
